// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the multi-cycle multiply/divide units and the HI/LO write.
// Optional divide-by-zero trap: define MULTDIV_ZERO_CHECK_EN.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  input  logic divisor_zero,
  output logic unit_clr,
  output logic divOrMult,
  output logic HILO_W,
  output logic busy,
  output logic done,
  output logic div_zero_exc
);

  // state | meaning
  // IDLE  | waiting for start_mult / start_div
  // RUN   | unit computing; counter runs CYCLES-1 down to 0
  // WRITE | HI/LO write enable for one cycle
  // DONE  | result-valid pulse for one cycle
  // EXC   | divide-by-zero exception pulse (zero-check builds only)
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    EXC   = 3'd4
  } state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  state_t     state, state_nxt;
  logic [5:0] count, count_nxt;
  logic       mode, mode_nxt;
  logic       start_any;
  logic       zero_trap;

  assign start_any = start_mult | start_div;

`ifdef MULTDIV_ZERO_CHECK_EN
  // A simultaneous multiply wins, so only a lone divide can trap.
  assign zero_trap    = start_div & ~start_mult & divisor_zero;
  assign div_zero_exc = (state == EXC);
`else
  logic unused_divisor_zero;
  assign unused_divisor_zero = divisor_zero;
  assign zero_trap           = 1'b0;
  assign div_zero_exc        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 6'd0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      mode  <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    mode_nxt  = mode;
    unit_clr  = 1'b0;
    HILO_W    = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_any) begin
          mode_nxt = start_mult;
          if (zero_trap) begin
            state_nxt = EXC;
          end else begin
            unit_clr  = 1'b1;
            state_nxt = RUN;
            count_nxt = start_mult ? MULT_LOAD : DIV_LOAD;
          end
        end
      end
      RUN: begin
        if (count == 6'd0) state_nxt = WRITE;
        else               count_nxt = count - 6'd1;
      end
      WRITE: begin
        HILO_W    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      EXC: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // The units must not be restarted by a request the reset is discarding.
    if (reset) unit_clr = 1'b0;
  end

  assign divOrMult = mode;

  hilo_done_exclusive: assert property (@(posedge clk) !(HILO_W && done));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed scenario table, hand sequences and a random
// run, all compared against an age-based reference model.
module tb_muldiv_ctrl;
  localparam int MC = 32;
  localparam int DC = 32;
  localparam int TR = 128;
`ifdef MULTDIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_mult = 1'b0;
  logic start_div = 1'b0;
  logic divisor_zero = 1'b0;
  logic unit_clr, divOrMult, HILO_W, busy, done, div_zero_exc;

  int checks = 0;
  int errors = 0;

  // model: age = cycles since accept (0 = idle); exc = exception cycle pending
  int m_age = 0;
  int m_cyc = MC;
  bit m_mode = 1'b0;
  bit m_exc = 1'b0;

  // bits: [5] unit_clr [4] divOrMult [3] HILO_W [2] busy [1] done [0] div_zero_exc
  logic [5:0] trace [TR];

  always #5 clk = ~clk;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .divisor_zero(divisor_zero), .unit_clr(unit_clr), .divOrMult(divOrMult),
    .HILO_W(HILO_W), .busy(busy), .done(done), .div_zero_exc(div_zero_exc)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit trap(input logic sm, input logic sd, input logic dz);
    return ZC && sd && !sm && dz;
  endfunction

  function automatic logic [5:0] model_out(input logic r, input logic sm,
                                           input logic sd, input logic dz);
    logic [5:0] o;
    o    = '0;
    o[5] = !r && m_age == 0 && !m_exc && (sm || sd) && !trap(sm, sd, dz);
    o[4] = m_mode;
    o[3] = (m_age == m_cyc + 1);
    o[2] = (m_age > 0) || m_exc;
    o[1] = (m_age == m_cyc + 2);
    o[0] = m_exc;
    return o;
  endfunction

  task automatic model_step(input logic r, input logic sm, input logic sd, input logic dz);
    if (r) begin
      m_age = 0; m_exc = 1'b0; m_mode = 1'b0;
    end else if (m_exc) begin
      m_exc = 1'b0;
    end else if (m_age == 0) begin
      if (sm || sd) begin
        m_mode = sm;
        if (trap(sm, sd, dz)) m_exc = 1'b1;
        else begin
          m_age = 1;
          m_cyc = sm ? MC : DC;
        end
      end
    end else begin
      m_age = (m_age == m_cyc + 2) ? 0 : m_age + 1;
    end
  endtask

  task automatic tick(input logic r, input logic sm, input logic sd, input logic dz,
                      input int idx);
    logic [5:0] act, exp;
    @(posedge clk); #1;
    reset = r; start_mult = sm; start_div = sd; divisor_zero = dz;
    @(negedge clk);
    act = {unit_clr, divOrMult, HILO_W, busy, done, div_zero_exc};
    exp = model_out(r, sm, sd, dz);
    check("cycle_outputs", int'(act), int'(exp));
    if (idx >= 0 && idx < TR) trace[idx] = act;
    model_step(r, sm, sd, dz);
  endtask

  task automatic clear_trace();
    for (int i = 0; i < TR; i++) trace[i] = '0;
  endtask

  function automatic int count_bit(input int b, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (trace[i][b]) n++;
    return n;
  endfunction

  function automatic int first_bit(input int b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (trace[i][b]) return i;
    return -1;
  endfunction

  function automatic int last_bit(input int b, input int lo, input int hi);
    int l = -1;
    for (int i = lo; i <= hi; i++) if (trace[i][b]) l = i;
    return l;
  endfunction

  typedef struct {
    string name;
    bit    sm, sd, dz;
    int    late_div;
    bit    exp_mode;
    int    exp_hilo;
    int    exp_done;
    int    exp_exc;
    int    exp_busy_end;
  } scen_t;

  scen_t tbl [5];

  initial begin
    tbl[0] = '{"mult",      1, 0, 0, -1, 1, 33, 34, -1, 34};
    tbl[1] = '{"div",       0, 1, 0, -1, 0, 33, 34, -1, 34};
    tbl[2] = '{"collision", 1, 1, 0, 10, 1, 33, 34, -1, 34};
    tbl[3] = '{"mult_dz",   1, 1, 1, -1, 1, 33, 34, -1, 34};
    if (ZC) tbl[4] = '{"div_zero", 0, 1, 1, -1, 0, -1, -1, 1, 1};
    else    tbl[4] = '{"div_zero", 0, 1, 1, -1, 0, 33, 34, -1, 34};

    // Table-driven single-operation scenarios
    foreach (tbl[k]) begin
      clear_trace();
      tick(1, 0, 0, 0, -1);
      for (int c = 0; c <= 44; c++)
        tick(0, (c == 0) && tbl[k].sm, ((c == 0) && tbl[k].sd) || (c == tbl[k].late_div),
             tbl[k].dz, c);
      check({tbl[k].name, "_reset_state"}, int'(trace[0] & 6'b011111), 0);
      check({tbl[k].name, "_unit_clr0"}, int'(trace[0][5]), (tbl[k].exp_exc < 0) ? 1 : 0);
      check({tbl[k].name, "_unit_clr_cnt"}, count_bit(5, 0, 44), (tbl[k].exp_exc < 0) ? 1 : 0);
      check({tbl[k].name, "_divOrMult"}, int'(trace[1][4]), int'(tbl[k].exp_mode));
      check({tbl[k].name, "_hilo_cycle"}, first_bit(3, 0, 44), tbl[k].exp_hilo);
      check({tbl[k].name, "_hilo_cnt"}, count_bit(3, 0, 44), (tbl[k].exp_hilo >= 0) ? 1 : 0);
      check({tbl[k].name, "_done_cycle"}, first_bit(1, 0, 44), tbl[k].exp_done);
      check({tbl[k].name, "_exc_cycle"}, first_bit(0, 0, 44), tbl[k].exp_exc);
      check({tbl[k].name, "_exc_cnt"}, count_bit(0, 0, 44), (tbl[k].exp_exc >= 0) ? 1 : 0);
      check({tbl[k].name, "_busy_first"}, first_bit(2, 0, 44), 1);
      check({tbl[k].name, "_busy_last"}, last_bit(2, 0, 44), tbl[k].exp_busy_end);
      if (tbl[k].exp_hilo >= 0)
        check({tbl[k].name, "_mode_held"}, int'(trace[34][4]), int'(tbl[k].exp_mode));
    end

    // Start coinciding with reset is dropped
    clear_trace();
    tick(1, 0, 0, 0, -1);
    tick(1, 1, 1, 0, 0);
    tick(0, 0, 0, 0, 1);
    check("reset_start_unit_clr", int'(trace[0][5]), 0);
    check("reset_start_busy", int'(trace[1][2]), 0);

    // Reset mid-RUN
    clear_trace();
    tick(1, 0, 0, 0, -1);
    for (int c = 0; c <= 40; c++) tick(c == 15, c == 0, 0, 0, c);
    check("midreset_busy15", int'(trace[15][2]), 1);
    check("midreset_busy16", int'(trace[16][2]), 0);
    check("midreset_hilo", count_bit(3, 15, 40), 0);
    check("midreset_done", count_bit(1, 15, 40), 0);
    check("midreset_mode", int'(trace[16][4]), 0);

    // Continuous start_div: back-to-back accepts
    clear_trace();
    tick(1, 0, 0, 0, -1);
    for (int c = 0; c <= 69; c++) tick(0, 0, 1, 0, c);
    check("b2b_accepts", count_bit(5, 0, 69), 2);
    check("b2b_accept2", first_bit(5, 1, 69), 35);
    check("b2b_hilo_cnt", count_bit(3, 0, 69), 2);
    check("b2b_hilo1", first_bit(3, 0, 69), 33);
    check("b2b_hilo2", last_bit(3, 0, 69), 68);

    // Random traffic against the model
    tick(1, 0, 0, 0, -1);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
